// File: rtl/hmmm_mem_responder.sv
`default_nettype none
// ============================================================================
// hmmm_mem_responder : HMMM core bus memory responder with byte-serial boot
// loader. Optional write protection of the loaded image: HMMM_MEM_WPROT_EN.
// Revision: 1.0
// ============================================================================
module hmmm_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int HI_W   = 7,
  parameter int LO_W   = 8
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Adr,
  input  logic              MemWrite,
  output logic [HI_W-1:0]   MemData1,
  inout  wire  [LO_W-1:0]   MemData2,
  input  logic              ld_valid,
  input  logic [LO_W-1:0]   ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   prog_len
`ifdef HMMM_MEM_WPROT_EN
  ,
  output logic              wp_err
`endif
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE_A     = 1;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ld_addr;
  logic [HI_W-1:0]   mem_hi [DEPTH];
  logic [LO_W-1:0]   mem_lo [DEPTH];
  logic              store_req;
  logic              store_commit;

  // ph1 carries no state here; it is part of the bus interface only.
  logic unused_ph1;
  assign unused_ph1 = ph1;

  assign ld_ready  = (state != RUN);
  assign cpu_reset = (state != RUN) | reset;
  assign store_req = (state == RUN) & MemWrite;

`ifdef HMMM_MEM_WPROT_EN
  logic drop;
  assign drop         = ({1'b0, Adr} < prog_len);
  assign store_commit = store_req & ~drop;
`else
  assign store_commit = store_req;
`endif

  assign MemData1 = mem_hi[Adr];
  assign MemData2 = MemWrite ? {LO_W{1'bz}} : mem_lo[Adr];

  always_ff @(posedge ph2) begin
    if (reset) begin
      state    <= LOAD_LO;
      ld_addr  <= '0;
      prog_len <= '0;
`ifdef HMMM_MEM_WPROT_EN
      wp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD_LO: begin
          if (ld_valid) state <= LOAD_HI;
        end
        LOAD_HI: begin
          if (ld_valid) begin
            prog_len <= {1'b0, ld_addr} + {1'b0, ONE_A};
            if (ld_last || (ld_addr == LAST_ADDR)) begin
              state <= RUN;
            end else begin
              ld_addr <= ld_addr + ONE_A;
              state   <= LOAD_LO;
            end
          end
        end
        RUN: begin
`ifdef HMMM_MEM_WPROT_EN
          if (MemWrite && drop) wp_err <= 1'b1;
`endif
        end
        default: state <= LOAD_LO;
      endcase
    end
  end

  // Storage is never cleared; a reset cycle simply blocks all writes.
  always_ff @(posedge ph2) begin
    if (!reset) begin
      if (state == LOAD_LO && ld_valid) mem_lo[ld_addr] <= ld_data;
      if (state == LOAD_HI && ld_valid) mem_hi[ld_addr] <= ld_data[HI_W-1:0];
      if (store_commit) begin
        mem_lo[Adr] <= MemData2;
        mem_hi[Adr] <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hmmm_mem_responder.sv
`default_nettype none
// Testbench for hmmm_mem_responder: directed load/store scenarios plus random
// traffic, all compared every cycle against a behavioural memory model.
module tb_hmmm_mem_responder;

`ifdef HMMM_MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic       ph1 = 0, ph2 = 0, reset = 1;
  logic [7:0] Adr = 0;
  logic       MemWrite = 0;
  logic [7:0] md_drv = 0;
  wire  [7:0] md2;
  logic [6:0] MemData1;
  logic       ld_valid = 0;
  logic [7:0] ld_data = 0;
  logic       ld_last = 0;
  logic       ld_ready, cpu_reset;
  logic [8:0] prog_len;
  logic       wp_err;

  assign md2 = MemWrite ? md_drv : 8'bz;

  hmmm_mem_responder dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .Adr(Adr), .MemWrite(MemWrite),
    .MemData1(MemData1), .MemData2(md2), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_reset(cpu_reset), .prog_len(prog_len)
`ifdef HMMM_MEM_WPROT_EN
    , .wp_err(wp_err)
`endif
  );

`ifndef HMMM_MEM_WPROT_EN
  assign wp_err = 1'b0;
`endif

  // ph1 high 1..4, ph2 high 6..9, period 10
  initial forever begin
    #1 ph1 = 1; #3 ph1 = 0; #2 ph2 = 1; #3 ph2 = 0; #1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: image words, which halves are known, loader progress.
  logic [6:0] m_hi [256];
  logic [7:0] m_lo [256];
  bit         k_hi [256];
  bit         k_lo [256];
  bit         m_run = 0, m_second = 0, m_wp = 0;
  int         m_addr = 0, m_plen = 0;
  bit         compare_on = 0;

  always @(posedge ph2) begin
    if (reset) begin
      m_run = 0; m_second = 0; m_addr = 0; m_plen = 0; m_wp = 0;
    end else if (!m_run) begin
      if (ld_valid) begin
        if (!m_second) begin
          m_lo[m_addr] = ld_data; k_lo[m_addr] = 1; m_second = 1;
        end else begin
          m_hi[m_addr] = ld_data[6:0]; k_hi[m_addr] = 1; m_second = 0;
          m_plen = m_addr + 1;
          if (ld_last || m_addr == 255) m_run = 1;
          else m_addr = m_addr + 1;
        end
      end
    end else if (MemWrite) begin
      if (WPROT && int'(Adr) < m_plen) m_wp = 1;
      else begin
        m_lo[Adr] = md_drv; m_hi[Adr] = 7'h0; k_lo[Adr] = 1; k_hi[Adr] = 1;
      end
    end
  end

  always @(negedge ph1) begin
    if (compare_on) begin
      chk("ld_ready", 32'(ld_ready), 32'(!m_run));
      chk("cpu_reset", 32'(cpu_reset), 32'(!m_run || reset));
      chk("prog_len", 32'(prog_len), 32'(m_plen));
      chk("wp_err", 32'(wp_err), 32'(m_wp));
      if (k_hi[Adr]) chk("MemData1", 32'(MemData1), 32'(m_hi[Adr]));
      if (MemWrite) chk("MemData2_released", 32'(md2), 32'(md_drv));
      else if (k_lo[Adr]) chk("MemData2", 32'(md2), 32'(m_lo[Adr]));
    end
  end

  task automatic tick();
    @(negedge ph2);
  endtask

  task automatic send(input logic [7:0] b, input bit last, input bit gap);
    ld_valid = 1; ld_data = b; ld_last = last;
    tick();
    ld_valid = 0; ld_last = 0;
    if (gap) begin
      ld_data = 8'($urandom);
      tick();
    end
  endtask

  task automatic rd_lit(input string nm, input logic [7:0] a, input logic [14:0] w);
    Adr = a; MemWrite = 0;
    #1;
    chk({nm, "_hi"}, 32'(MemData1), 32'(w[14:8]));
    chk({nm, "_lo"}, 32'(md2), 32'(w[7:0]));
  endtask

  task automatic do_reset();
    reset = 1; ld_valid = 0; MemWrite = 0;
    tick();
    reset = 0;
  endtask

  task automatic load6(input bit gap);
    logic [7:0] img [6];
    img = '{8'h11, 8'h05, 8'h22, 8'h06, 8'h33, 8'h47};
    for (int i = 0; i < 6; i++) begin
      send(img[i], i == 5, gap);
      if (i == 4) chk("cpu_reset_before_last", 32'(cpu_reset), 32'd1);
    end
    chk("cpu_reset_after_last", 32'(cpu_reset), 32'd0);
    chk("ld_ready_after_last", 32'(ld_ready), 32'd0);
    chk("prog_len_3", 32'(prog_len), 32'd3);
    chk("model_w0", 32'({m_hi[0], m_lo[0]}), 32'h0511);
    chk("model_plen", 32'(m_plen), 32'd3);
    rd_lit("word0", 8'h00, 15'h0511);
    rd_lit("word1", 8'h01, 15'h0622);
    rd_lit("word2", 8'h02, 15'h4733);
  endtask

  initial begin
    repeat (2) tick();
    compare_on = 1;
    #1;
    chk("reset_ld_ready", 32'(ld_ready), 32'd1);
    chk("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reset_prog_len", 32'(prog_len), 32'd0);
    reset = 0;
    tick();

    load6(0);
    do_reset();
    load6(1);

    // RUN store: bus released during the store, then read back
    Adr = 8'h80; MemWrite = 1; md_drv = 8'h5A;
    #1 chk("store_release", 32'(md2), 32'h5A);
    tick();
    rd_lit("word80", 8'h80, 15'h005A);

    if (WPROT) begin
      Adr = 8'h01; MemWrite = 1; md_drv = 8'hEE;
      tick();
      rd_lit("wp_word1", 8'h01, 15'h0622);
      chk("wp_err_set", 32'(wp_err), 32'd1);
      Adr = 8'h03; MemWrite = 1; md_drv = 8'h77;
      tick();
      rd_lit("wp_word3", 8'h03, 15'h0077);
      chk("wp_err_sticky", 32'(wp_err), 32'd1);
    end

    // Reset after 3 bytes; word1 keeps its old upper half
    do_reset();
    send(8'hA1, 0, 0); send(8'h0B, 0, 0); send(8'hA2, 0, 0);
    chk("partial_plen", 32'(prog_len), 32'd1);
    reset = 1;
    tick();
    chk("midreset_plen", 32'(prog_len), 32'd0);
    chk("midreset_ready", 32'(ld_ready), 32'd1);
    reset = 0;
    #1 chk("midreset_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    send(8'hB1, 1, 0);
    chk("lo_last_ignored", 32'(cpu_reset), 32'd1);
    send(8'h7C, 1, 0);
    chk("reload_plen", 32'(prog_len), 32'd1);
    rd_lit("reload_w0", 8'h00, 15'h7CB1);
    rd_lit("kept_w1", 8'h01, 15'h06A2);

    // Full-depth image without ld_last
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0, 0);
      send(8'(i + 3), 0, 0);
    end
    chk("full_plen", 32'(prog_len), 32'd256);
    chk("full_cpu_reset", 32'(cpu_reset), 32'd0);
    send(8'hFF, 0, 0);
    rd_lit("full_w0", 8'h00, 15'h0300);
    rd_lit("full_w255", 8'hFF, 15'h02FF);

    // Random traffic
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = 8'($urandom);
        ld_last  = ($urandom_range(0, 15) == 0);
        Adr      = (r[0]) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        MemWrite = ($urandom_range(0, 3) == 0);
        md_drv   = 8'($urandom);
        reset    = ($urandom_range(0, 499) == 0);
        tick();
      end
    end

    reset = 0; ld_valid = 0; MemWrite = 0;
    tick();
    compare_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
